// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the round-robin arbiter family.
// Holds the FSM state encoding and the requester count and index width,
// so that 4- and 16-way variants can reuse the same names.
package rr_arbiter8_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;

endpackage

// File: rtl/rr_pick8.sv
// Purpose: combinational round-robin picker for 8 requesters; first set req bit at or after ptr.
// Latency: zero cycles (purely combinational).
// Backpressure: none; pick_valid is low when no request is present.
// Ports: req[7:0] request vector, ptr[2:0] highest-priority index,
//        pick_id[2:0] chosen index, pick_valid any request present.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [ARB_N-1:0]   req,
  input  logic [ARB_IDW-1:0] ptr,
  output logic [ARB_IDW-1:0] pick_id,
  output logic               pick_valid
);

  logic [ARB_N-1:0]   rot;
  logic [ARB_IDW-1:0] off;
  logic [3:0]         or_l1;
  logic [1:0]         or_l2;

  // Rotate right by ptr so the highest-priority requester lands at bit 0,
  // then find the lowest set bit; adding ptr back wraps naturally in 3 bits.
  always_comb begin
    rot = 8'({req, req} >> ptr);
    off = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) off = 3'(i);
    end
    pick_id = ptr + off;
  end

  // Balanced 2-input OR tree for the any-request flag.
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_or_l1
      assign or_l1[g] = req[2*g] | req[2*g+1];
    end
    for (g = 0; g < 2; g++) begin : g_or_l2
      assign or_l2[g] = or_l1[2*g] | or_l1[2*g+1];
    end
  endgenerate

  assign pick_valid = or_l2[0] | or_l2[1];

endmodule

// File: rtl/rr_arbiter8.sv
// Purpose: 8-requester round-robin arbiter; one-hot grant held until done or holder drops req.
// Latency: req -> grant 1 cycle; exactly one idle cycle between consecutive grants.
// Backpressure: non-holders wait (nothing queued); ARB_TIMEOUT_EN adds a watchdog that revokes after MAX_HOLD cycles.
// Ports: clk, rst (sync, active-high), req[7:0], done -> grant[7:0], grant_id[2:0], busy, timeout.
// Optional feature macro: ARB_TIMEOUT_EN (hold watchdog; timeout tied low when undefined).
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter logic [ARB_IDW-1:0] PRIO_RESET = 3'd0,
  parameter int                 MAX_HOLD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ARB_N-1:0]   req,
  input  logic               done,
  output logic [ARB_N-1:0]   grant,
  output logic [ARB_IDW-1:0] grant_id,
  output logic               busy,
  output logic               timeout
);

  generate
    if (MAX_HOLD < 2) begin : g_bad_hold
      $error("rr_arbiter8: MAX_HOLD must be at least 2");
    end
  endgenerate

  arb_state_t         state_q, state_d;
  logic [ARB_IDW-1:0] ptr_q, ptr_d;
  logic [ARB_IDW-1:0] gid_q, gid_d;
  logic [ARB_IDW-1:0] pick_id;
  logic               pick_valid;
  logic               release_req;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  rr_pick8 u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  // Holder either signals completion or withdraws its own request.
  assign release_req = done | ~req[gid_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= PRIO_RESET;
      gid_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_GRANT;
          gid_d   = pick_id;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_GRANT: begin
        // Winner drops to lowest priority on any release.
        if (release_req) begin
          state_d = ARB_IDLE;
          ptr_d   = gid_q + 3'd1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CW'(MAX_HOLD - 1)) begin
          state_d = ARB_IDLE;
          ptr_d   = gid_q + 3'd1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy     = (state_q == ARB_GRANT);
  assign grant    = busy ? (8'd1 << gid_q) : 8'd0;
  assign grant_id = gid_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic
// checked every cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int         MH = 4;
  localparam logic [2:0] PR = 3'd0;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;

  int errs   = 0;
  int checks = 0;

  // Behavioural model state
  bit m_busy;
  bit m_to;
  int m_id;
  int m_ptr;
  int m_hold;

  rr_arbiter8 #(.PRIO_RESET(PR), .MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL sim_watchdog: got=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, advance model with current inputs.
  task automatic step();
    bit n_busy, n_to;
    int n_id, n_ptr, n_hold;
    @(negedge clk);
    chk("grant", grant, m_busy ? (32'd1 << m_id) : 32'd0);
    chk("busy", busy, m_busy);
    chk("timeout", timeout, m_to);
    if (m_busy) chk("grant_id", grant_id, m_id);
    n_busy = m_busy; n_to = 1'b0; n_id = m_id; n_ptr = m_ptr; n_hold = m_hold;
    if (rst) begin
      n_busy = 0; n_id = 0; n_ptr = PR; n_hold = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          n_busy = 1; n_id = (m_ptr + k) % 8; n_hold = 0;
          break;
        end
      end
    end else if (done || !req[m_id]) begin
      n_busy = 0; n_ptr = (m_id + 1) % 8;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_hold == MH - 1) begin
        n_busy = 0; n_ptr = (m_id + 1) % 8; n_to = 1'b1;
      end else begin
        n_hold = m_hold + 1;
      end
`endif
    end
    @(posedge clk);
    m_busy = n_busy; m_to = n_to; m_id = n_id; m_ptr = n_ptr; m_hold = n_hold;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_busy(input string tag);
    for (int i = 0; i < 20 && !busy; i++) step();
    chk(tag, busy, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    @(posedge clk);
    m_busy = 0; m_to = 0; m_id = 0; m_ptr = PR; m_hold = 0;
    #1;
    rst = 1'b0;

    // 1: idle after reset
    chk("rst_gid", grant_id, 3'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t1_grant", grant, 8'h00);
      chk("t1_busy", busy, 1'b0);
      chk("t1_to", timeout, 1'b0);
    end

    // 2: two requesters alternate 01,80,01,80
    begin
      int g = 0;
      bit prev = 0;
      req = 8'h81;
      for (int i = 0; i < 8; i++) begin
        done = m_busy;
        step();
        if (busy && !prev) begin
          chk("t2_seq", grant, (g % 2) ? 8'h80 : 8'h01);
          g++;
        end
        prev = busy;
      end
      chk("t2_count", g, 4);
    end

    // 3: all requesting, ids 0..7 then wrap to 0
    do_reset();
    begin
      int g = 0;
      bit prev = 0;
      req = 8'hFF;
      for (int i = 0; i < 18; i++) begin
        done = m_busy;
        step();
        if (busy && !prev) begin
          chk("t3_seq", grant_id, g % 8);
          g++;
        end
        prev = busy;
      end
      chk("t3_count", g, 9);
    end

    // 4: holder abandons; priority moves past it
    do_reset();
    req = 8'h08;
    wait_busy("t4_wait");
    chk("t4_id3", grant_id, 3'd3);
    req = 8'h00;
    step();
    chk("t4_drop", grant, 8'h00);
    req = 8'h18;
    step();
    chk("t4_id4", grant_id, 3'd4);
    chk("t4_busy", busy, 1'b1);

    // 5: reset in the middle of a grant to 5
    done = 1'b1;
    step();
    done = 1'b0;
    req = 8'h20;
    step();
    chk("t5_id5", grant_id, 3'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_grant", grant, 8'h00);
    chk("t5_busy", busy, 1'b0);
    req = 8'h21;
    step();
    chk("t5_ptr0", grant, 8'h01);

`ifdef ARB_TIMEOUT_EN
    // 6: watchdog revokes after MH cycles; done on final cycle is a normal release
    do_reset();
    req = 8'h04;
    wait_busy("t6_wait");
    begin
      int n = 0;
      while (busy && n < 20) begin
        n++;
        step();
      end
      chk("t6_hold", n, MH);
      chk("t6_to", timeout, 1'b1);
    end
    step();
    chk("t6_pulse", timeout, 1'b0);
    chk("t6_regrant", busy, 1'b1);
    for (int k = 1; k <= MH; k++) begin
      done = (k == MH);
      step();
    end
    done = 1'b0;
    chk("t6_done_busy", busy, 1'b0);
    chk("t6_done_to", timeout, 1'b0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      rst  = ($urandom_range(63) == 0);
      req  = ($urandom_range(3) == 0) ? 8'(1 << $urandom_range(7)) : 8'($urandom);
      done = ($urandom_range(3) == 0);
      step();
    end
    rst = 1'b0; req = 8'h00; done = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
